// File: rtl/can_pkg.sv
// Shared CAN definitions: bus levels, bit-timing field widths and the
// helper that turns a clamped phase-error magnitude into a signed delta.
package can_pkg;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam int STUFF_LEN_DEFAULT = 5;

    localparam int TQ_POS_W   = 5;
    localparam int TSEG1_W    = 4;
    localparam int TSEG2_W    = 3;
    localparam int SJW_W      = 2;
    localparam int TQ_TOTAL_W = 5;
    localparam int RESYNC_W   = 4;

    typedef struct packed {
        logic                  neg;
        logic [TQ_TOTAL_W-1:0] mag;
    } phase_err_t;

    // Magnitude is already clamped to the jump width (<= 4), so it fits RESYNC_W.
    function automatic logic [RESYNC_W-1:0] to_delta(input phase_err_t err);
        logic [RESYNC_W-1:0] mag_n;
        mag_n = err.mag[RESYNC_W-1:0];
        if (err.neg) begin
            to_delta = 4'd0 - mag_n;
        end else begin
            to_delta = mag_n;
        end
    endfunction

endpackage

// File: rtl/can_destuff.sv
// Stuff-bit removal: tracks the current run of equal sampled bits and either
// forwards the bit, drops a correct stuff bit or flags a stuff violation.
module can_destuff
    import can_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_point,
    input  logic b,
    input  logic destuff_en,
    output logic rx_bit,
    output logic rx_bit_valid,
    output logic stuff_bit_drop,
    output logic stuff_err
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             last_bit_r;
    logic             last_bit_s;
    logic             bit_s;
    logic             valid_s;
    logic             drop_s;
    logic             err_s;

    // Next run-length state and sample outputs for this cycle.
    always_comb begin
        cnt_s      = cnt_r;
        last_bit_s = last_bit_r;
        bit_s      = rx_bit;
        valid_s    = 1'b0;
        drop_s     = 1'b0;
        err_s      = 1'b0;
        if (!destuff_en) begin
            cnt_s = '0;
            if (sample_point) begin
                bit_s   = b;
                valid_s = 1'b1;
            end else begin
                bit_s = rx_bit;
            end
        end else if (sample_point) begin
            // The stuff bit starts the next run, so the count restarts at one.
            if (cnt_r == CNT_MAX) begin
                cnt_s      = CNT_ONE;
                last_bit_s = b;
                if (b == last_bit_r) begin
                    err_s = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                bit_s      = b;
                valid_s    = 1'b1;
                last_bit_s = b;
                if ((cnt_r == '0) || (b != last_bit_r)) begin
                    cnt_s = CNT_ONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Run-length state and registered sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r          <= '0;
            last_bit_r     <= CAN_RECESSIVE;
            rx_bit         <= CAN_RECESSIVE;
            rx_bit_valid   <= 1'b0;
            stuff_bit_drop <= 1'b0;
            stuff_err      <= 1'b0;
        end else begin
            cnt_r          <= cnt_s;
            last_bit_r     <= last_bit_s;
            rx_bit         <= bit_s;
            rx_bit_valid   <= valid_s;
            stuff_bit_drop <= drop_s;
            stuff_err      <= err_s;
        end
    end

endmodule

// File: rtl/can_rx_bit_sampler.sv
// CAN receive bit sampler: synchronises can_rx, derives hard-sync and
// SJW-limited resync requests from falling edges, and destuffs sampled bits.
module can_rx_bit_sampler
    import can_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STUFF_LEN   = STUFF_LEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                can_rx,
    input  logic                tq_tick,
    input  logic                sample_point,
    input  logic [TQ_POS_W-1:0] tq_position,
    input  logic [TSEG1_W-1:0]  tseg1,
    input  logic [TSEG2_W-1:0]  tseg2,
    input  logic [SJW_W-1:0]    sjw,
    input  logic                hard_sync_en,
    input  logic                tx_dominant,
    input  logic                destuff_en,
    output logic                rx_bit,
    output logic                rx_bit_valid,
    output logic                stuff_bit_drop,
    output logic                stuff_err,
    output logic                hard_sync,
    output logic                resync_valid,
    output logic [RESYNC_W-1:0] resync_delta
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    logic                   rx_ref_r;
    logic                   edge_s;
    logic                   resync_done_r;
    logic                   resync_done_s;
    logic [TQ_TOTAL_W-1:0]  total_s;
    logic [TQ_TOTAL_W-1:0]  tseg1_end_s;
    logic [TQ_TOTAL_W-1:0]  jump_s;
    phase_err_t             err_raw_s;
    phase_err_t             err_s;
    logic                   err_nonzero_s;
    logic                   hard_sync_s;
    logic                   resync_s;

    assign rx_s   = sync_r[SYNC_STAGES-1];
    assign edge_s = tq_tick && (rx_ref_r == CAN_RECESSIVE) && (rx_s == CAN_DOMINANT);

    // Metastability synchroniser and edge reference captured on every TQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r   <= {SYNC_STAGES{CAN_RECESSIVE}};
            rx_ref_r <= CAN_RECESSIVE;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], can_rx};
            if (tq_tick) begin
                rx_ref_r <= rx_s;
            end else begin
                rx_ref_r <= rx_ref_r;
            end
        end
    end

    // Phase error of the edge, clamped to the jump width sjw+1.
    always_comb begin
        total_s     = 5'd1 + {1'b0, tseg1} + {2'b00, tseg2};
        tseg1_end_s = 5'd1 + {1'b0, tseg1};
        jump_s      = {3'b000, sjw} + 5'd1;
        err_raw_s   = '0;
        if (tq_position <= 5'd1) begin
            err_raw_s = '0;
        end else if (tq_position <= tseg1_end_s) begin
            err_raw_s.neg = 1'b0;
            err_raw_s.mag = tq_position - 5'd1;
        end else begin
            err_raw_s.neg = 1'b1;
            err_raw_s.mag = total_s + 5'd1 - tq_position;
        end
        err_s = err_raw_s;
        if (err_raw_s.mag > jump_s) begin
            err_s.mag = jump_s;
        end else begin
            err_s.mag = err_raw_s.mag;
        end
        err_nonzero_s = (err_s.mag != 5'd0);
    end

    // Sync arbitration: hard sync first, then one resync per bit.
    always_comb begin
        hard_sync_s = edge_s && hard_sync_en;
        resync_s    = edge_s && !hard_sync_en && !resync_done_r && err_nonzero_s
                      && !(tx_dominant && !err_s.neg);
        if (hard_sync_s || resync_s) begin
            resync_done_s = 1'b1;
        end else if (sample_point) begin
            resync_done_s = 1'b0;
        end else begin
            resync_done_s = resync_done_r;
        end
    end

    // Registered sync outputs; resync_delta holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resync_done_r <= 1'b0;
            hard_sync     <= 1'b0;
            resync_valid  <= 1'b0;
            resync_delta  <= 4'd0;
        end else begin
            resync_done_r <= resync_done_s;
            hard_sync     <= hard_sync_s;
            resync_valid  <= resync_s;
            if (resync_s) begin
                resync_delta <= to_delta(err_s);
            end else begin
                resync_delta <= resync_delta;
            end
        end
    end

    can_destuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_destuff (
        .clk            (clk),
        .rst            (rst),
        .sample_point   (sample_point),
        .b              (rx_s),
        .destuff_en     (destuff_en),
        .rx_bit         (rx_bit),
        .rx_bit_valid   (rx_bit_valid),
        .stuff_bit_drop (stuff_bit_drop),
        .stuff_err      (stuff_err)
    );

endmodule

// File: tb/tb_can_rx_bit_sampler.sv
// Directed self-checking bench for can_rx_bit_sampler: sync arithmetic,
// priority rules, destuffing, stuff errors, reset and destuff disable.
module tb_can_rx_bit_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       can_rx;
    logic       tq_tick;
    logic       sample_point;
    logic [4:0] tq_position;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       hard_sync_en;
    logic       tx_dominant;
    logic       destuff_en;
    logic       rx_bit;
    logic       rx_bit_valid;
    logic       stuff_bit_drop;
    logic       stuff_err;
    logic       hard_sync;
    logic       resync_valid;
    logic [3:0] resync_delta;

    int checks   = 0;
    int failures = 0;

    can_rx_bit_sampler dut (
        .clk            (clk),
        .rst            (rst),
        .can_rx         (can_rx),
        .tq_tick        (tq_tick),
        .sample_point   (sample_point),
        .tq_position    (tq_position),
        .tseg1          (tseg1),
        .tseg2          (tseg2),
        .sjw            (sjw),
        .hard_sync_en   (hard_sync_en),
        .tx_dominant    (tx_dominant),
        .destuff_en     (destuff_en),
        .rx_bit         (rx_bit),
        .rx_bit_valid   (rx_bit_valid),
        .stuff_bit_drop (stuff_bit_drop),
        .stuff_err      (stuff_err),
        .hard_sync      (hard_sync),
        .resync_valid   (resync_valid),
        .resync_delta   (resync_delta)
    );

    always #5 clk = ~clk;

    // Drive can_rx and let it clear the two-flop synchroniser.
    task automatic set_rx(input logic v);
        can_rx = v;
        repeat (3) @(negedge clk);
    endtask

    // One TQ pulse; on return the registered outputs of that tick are visible.
    task automatic pulse_tick(input logic [4:0] p, input logic sp);
        tq_tick      = 1'b1;
        sample_point = sp;
        tq_position  = p;
        @(negedge clk);
        tq_tick      = 1'b0;
        sample_point = 1'b0;
    endtask

    task automatic make_edge(input logic [4:0] p);
        set_rx(1'b1);
        pulse_tick(5'd1, 1'b0);
        set_rx(1'b0);
        pulse_tick(p, 1'b0);
    endtask

    task automatic sample_bit(input logic b);
        set_rx(b);
        pulse_tick(5'd6, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_bit !== 1'b1) begin failures++; $display("FAIL reset_rx_bit got=%0b exp=1", rx_bit); end
        checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err, hard_sync, resync_valid} !== 5'b0) begin
            failures++; $display("FAIL reset_pulses got=%b exp=00000", {rx_bit_valid, stuff_bit_drop, stuff_err, hard_sync, resync_valid}); end
        checks++; if (resync_delta !== 4'd0) begin failures++; $display("FAIL reset_delta got=%h exp=0", resync_delta); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sync;
        tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd0;
        make_edge(5'd3);
        checks++; if (resync_valid !== 1'b1) begin failures++; $display("FAIL sync_p3_valid got=%0b exp=1", resync_valid); end
        checks++; if (resync_delta !== 4'h1) begin failures++; $display("FAIL sync_p3_delta got=%h exp=1", resync_delta); end
        @(negedge clk);
        checks++; if (resync_valid !== 1'b0) begin failures++; $display("FAIL sync_one_cycle got=%0b exp=0", resync_valid); end
        sjw = 2'd3;
        pulse_tick(5'd6, 1'b1);
        make_edge(5'd7);
        checks++; if ({resync_valid, resync_delta} !== 5'b1_1110) begin failures++; $display("FAIL sync_p7 got=%b exp=11110", {resync_valid, resync_delta}); end
        pulse_tick(5'd6, 1'b1);
        make_edge(5'd8);
        checks++; if ({resync_valid, resync_delta} !== 5'b1_1111) begin failures++; $display("FAIL sync_p8 got=%b exp=11111", {resync_valid, resync_delta}); end
        make_edge(5'd4);
        checks++; if (resync_valid !== 1'b0) begin failures++; $display("FAIL sync_second_edge got=%0b exp=0", resync_valid); end
        checks++; if (resync_delta !== 4'hF) begin failures++; $display("FAIL sync_delta_hold got=%h exp=f", resync_delta); end
    endtask

    task automatic test_priority;
        pulse_tick(5'd6, 1'b1);
        hard_sync_en = 1'b1;
        make_edge(5'd4);
        checks++; if ({hard_sync, resync_valid} !== 2'b10) begin failures++; $display("FAIL prio_hard got=%b exp=10", {hard_sync, resync_valid}); end
        make_edge(5'd5);
        checks++; if (hard_sync !== 1'b1) begin failures++; $display("FAIL prio_hard_ignores_done got=%0b exp=1", hard_sync); end
        hard_sync_en = 1'b0;
        pulse_tick(5'd6, 1'b1);
        make_edge(5'd1);
        checks++; if ({hard_sync, resync_valid} !== 2'b00) begin failures++; $display("FAIL prio_p1 got=%b exp=00", {hard_sync, resync_valid}); end
        tx_dominant = 1'b1;
        make_edge(5'd3);
        checks++; if (resync_valid !== 1'b0) begin failures++; $display("FAIL prio_txdom_pos got=%0b exp=0", resync_valid); end
        make_edge(5'd8);
        checks++; if ({resync_valid, resync_delta} !== 5'b1_1111) begin failures++; $display("FAIL prio_txdom_neg got=%b exp=11111", {resync_valid, resync_delta}); end
        tx_dominant = 1'b0;
    endtask

    task automatic test_destuff;
        logic [6:0] bits;
        logic [6:0] exp_valid;
        logic [6:0] exp_drop;
        bits      = 7'b0100000;
        exp_valid = 7'b1011111;
        exp_drop  = 7'b0100000;
        destuff_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sample_bit(bits[i]);
            checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err} !== {exp_valid[i], exp_drop[i], 1'b0}) begin
                failures++; $display("FAIL destuff_bit%0d got=%b exp=%b", i, {rx_bit_valid, stuff_bit_drop, stuff_err}, {exp_valid[i], exp_drop[i], 1'b0}); end
            if (exp_valid[i]) begin
                checks++; if (rx_bit !== 1'b0) begin failures++; $display("FAIL destuff_val%0d got=%0b exp=0", i, rx_bit); end
            end
        end
    endtask

    task automatic test_stuff_err;
        for (int i = 0; i < 10; i++) begin
            sample_bit(1'b1);
            if (i == 5) begin
                checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err} !== 3'b001) begin
                    failures++; $display("FAIL stufferr_bit%0d got=%b exp=001", i, {rx_bit_valid, stuff_bit_drop, stuff_err}); end
            end else begin
                checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err, rx_bit} !== 4'b1001) begin
                    failures++; $display("FAIL stufferr_bit%0d got=%b exp=1001", i, {rx_bit_valid, stuff_bit_drop, stuff_err, rx_bit}); end
            end
        end
    endtask

    task automatic test_reset_disable;
        sample_bit(1'b0);
        for (int i = 0; i < 3; i++) sample_bit(1'b0);
        can_rx = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        checks++; if ({rx_bit, rx_bit_valid, stuff_bit_drop, stuff_err, hard_sync, resync_valid, resync_delta} !== 10'b1_00000_0000) begin
            failures++; $display("FAIL midrun_reset got=%b exp=1000000000", {rx_bit, rx_bit_valid, stuff_bit_drop, stuff_err, hard_sync, resync_valid, resync_delta}); end
        rst = 1'b0;
        @(negedge clk);
        destuff_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sample_bit(1'b0);
            checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err, rx_bit} !== 4'b1000) begin
                failures++; $display("FAIL nodestuff_bit%0d got=%b exp=1000", i, {rx_bit_valid, stuff_bit_drop, stuff_err, rx_bit}); end
        end
        destuff_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_bit(1'b0);
            checks++; if ({rx_bit_valid, stuff_bit_drop, stuff_err} !== 3'b100) begin
                failures++; $display("FAIL reenable_bit%0d got=%b exp=100", i, {rx_bit_valid, stuff_bit_drop, stuff_err}); end
        end
    endtask

    initial begin
        rst = 1'b1; can_rx = 1'b1; tq_tick = 1'b0; sample_point = 1'b0;
        tq_position = 5'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd0;
        hard_sync_en = 1'b0; tx_dominant = 1'b0; destuff_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_sync();
        test_priority();
        test_destuff();
        test_stuff_err();
        test_reset_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_rx_bit_sampler.md
Name: can_rx_bit_sampler

Overview:
Receive-side companion to the CAN time-quantum generator. It synchronises the raw CAN RX pin and detects recessive-to-dominant edges at TQ granularity. It computes the hard-sync and SJW-limited resynchronisation requests that feed back into the bit timing logic. It samples the bus at the sample point and removes stuff bits, delivering a destuffed bit stream and stuff-error flags to the CAN MAC.

Parameters:
SYNC_STAGES, 2, number of flops in the can_rx metastability synchroniser (min 2)
STUFF_LEN, 5, consecutive equal bits after which a stuff bit is expected

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
can_rx  in  1  raw bus pin (1 = recessive)
tq_tick  in  1  one-cycle time-quantum pulse from the TQ generator
sample_point  in  1  one-cycle pulse, coincident with a tq_tick
tq_position  in  5  current TQ within the bit, 1..total
tseg1  in  4  raw tseg1 field
tseg2  in  3  raw tseg2 field
sjw  in  2  raw SJW field; jump width = sjw+1
hard_sync_en  in  1  MAC is in bus-idle/intermission; the next edge is a hard sync
tx_dominant  in  1  this node is currently driving dominant
destuff_en  in  1  stuff-bit removal active (SOF through CRC)
rx_bit  out  1  sampled or destuffed bit value
rx_bit_valid  out  1  one-cycle pulse: rx_bit is a data bit
stuff_bit_drop  out  1  one-cycle pulse: a correct stuff bit was discarded
stuff_err  out  1  one-cycle pulse: stuff rule violated
hard_sync  out  1  one-cycle pulse: restart the bit at SYNC
resync_valid  out  1  one-cycle pulse: apply resync_delta
resync_delta  out  4  two's complement phase adjustment; positive lengthens PHASE1, negative shortens PHASE2

Behaviour:
- Reset values: all outputs 0 except rx_bit=1 (recessive). Synchroniser flops, edge reference and last_bit reset to 1. Stuff counter resets to 0. resync_done resets to 0. Reset is asynchronous and may abort any operation; no partial pulses after release.
- Synchroniser: can_rx passes through SYNC_STAGES flops to rx_s. All other logic uses rx_s only.
- Edge detection: evaluated only in tq_tick cycles. edge = (rx_ref==1 && rx_s==0), where rx_ref is rx_s captured at the previous tq_tick. rx_ref updates every tq_tick.
- Arithmetic: total = 1 + tseg1 + tseg2 (5-bit, no overflow). Let p = tq_position.
  - p==1: error 0; no resync.
  - 2 <= p <= 1+tseg1: e = +(p-1).
  - p > 1+tseg1: e = -(total+1-p).
  - |e| is clamped to sjw+1. Result is in -4..+4 and fits 4-bit signed.
- Sync priority on an edge, outputs registered one cycle after the tq_tick cycle:
  1. hard_sync_en=1: hard_sync pulses and resync_done is set. Hard sync ignores resync_done.
  2. Otherwise, resync_valid pulses with resync_delta if resync_done==0, e != 0, and not (tx_dominant==1 && e>0). resync_done is then set.
  3. Otherwise, no pulse.
- resync_done clears at every sample_point, giving at most one sync per bit.
- resync_delta holds its value between pulses. It is 0 after reset.
- Sampling: at sample_point the bit value b = rx_s. All sample outputs register in the following cycle (latency 1 clk).
- Sampling with destuff_en=0: rx_bit=b and rx_bit_valid pulses. The stuff counter is forced to 0.
- Sampling with destuff_en=1, counter cnt and last_bit:
  - cnt==STUFF_LEN and b==last_bit: stuff_err pulses, no rx_bit_valid, cnt=1, last_bit=b.
  - cnt==STUFF_LEN and b!=last_bit: stuff_bit_drop pulses, no rx_bit_valid, cnt=1, last_bit=b.
  - Otherwise: rx_bit=b and rx_bit_valid pulses. If cnt==0 or b!=last_bit then cnt=1, else cnt=cnt+1. last_bit=b.
- The stuff bit itself counts as the first bit of the next run.
- destuff_en falling clears cnt on the next clk. An edge and a sample_point in the same tq_tick are both processed independently.

Decomposition:
- Shared package can_pkg holds:
  - CAN_RECESSIVE/CAN_DOMINANT constants.
  - STUFF_LEN default.
  - Width constants for tq_position, tseg1, tseg2 and sjw, shared with can_tq_gen.
  - The total-TQ width.
- One sub-module, can_destuff: stuff counter, last_bit and the three sample outputs. It is driven by sample_point, b and destuff_en.

Test Plan:
- Sync: tseg1=5, tseg2=2, sjw=0, can_rx falls before the tq_tick with p=3 -> resync_valid and resync_delta=+1 (clamped from +2) one clk after that tick.
- Sync: same settings, sjw=3, edge at p=7 -> delta=-2; edge at p=8 -> delta=-1; second edge in the same bit -> no pulse.
- Priority: hard_sync_en=1 with an edge at p=4 -> hard_sync pulse, no resync_valid. Edge at p=1 with hard_sync_en=0 -> no pulse. tx_dominant=1, edge at p=3 -> suppressed; p=8 -> delta=-1.
- Destuff: destuff_en=1, sampled bits 0,0,0,0,0,1,0 -> five rx_bit_valid pulses with rx_bit=0, stuff_bit_drop on the sixth bit, then rx_bit_valid with rx_bit=0.
- Stuff error: sampled bits 1,1,1,1,1,1 with destuff_en=1 -> stuff_err on the sixth bit, no rx_bit_valid. Then bits 1,1,1,1 -> valid bits, no stuff expected until the run reaches 5.
- Reset and disable: assert rst mid-run (cnt=4) -> all outputs 0, rx_bit=1. With destuff_en=0, seven 0s -> seven rx_bit_valid pulses and no stuff events.
